fp_wb_arbiter: RTL and testbench
================================

Name: fp_wb_arbiter

Overview:
- Parametrised writeback merge stage for the FPU.
- Arbitrates N intermediate FP-unit writeback channels onto one registered FP writeback port.
- Merges the accepted FP result's exception flags with a concurrently accepted integer-side writeback's flags.
- Generalises the FPU's fixed two-source fflags merge to N channels, with selectable arbitration and back-pressure-tolerant output buffering.

Parameters:
- NUM_CHANNELS, 4, number of input writeback channels (2..8).
- DATA_WIDTH, 64, result width (FLEN).
- ID_WIDTH, 3, instruction id width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_done  in  NUM_CHANNELS  channel i has a result pending
- in_id  in  NUM_CHANNELS*ID_WIDTH  per-channel instruction id
- in_rd  in  NUM_CHANNELS*DATA_WIDTH  per-channel result
- in_fflags  in  NUM_CHANNELS*5  per-channel flags {NV,DZ,OF,UF,NX}
- in_ack  out  NUM_CHANNELS  one-hot grant; channel i's data captured this cycle
- wb_done  out  1  output result valid
- wb_id  out  ID_WIDTH  output id
- wb_rd  out  DATA_WIDTH  output result
- wb_ack  in  1  downstream accepts output this cycle
- int_done  in  1  integer-side writeback valid
- int_ack  in  1  integer-side writeback accepted
- int_fflags  in  5  integer-side flags
- fflags  out  5  flags to CSR for this cycle
- busy  out  1  wb_done or any in_done asserted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - wb_done=0; wb_id, wb_rd and the stored flags = 0.
  - Round-robin pointer = 0.
  - in_ack=0 (combinational; zero whenever no grant).
- Output register:
  - Holds one entry.
  - load_en = ~wb_done | wb_ack, so a new grant can load in the same cycle the current entry is acknowledged (full throughput, one result per cycle).
- Grant:
  - Generated only when load_en is true and at least one in_done is set.
  - At most one in_ack bit is set per cycle.
  - in_ack[i] is a function of the current in_done, the pointer and load_en only; no combinational path from in_rd or in_id.
- Latency: channel captured at cycle t appears with wb_done=1 at t+1.
- Round-robin (ARB_MODE=0):
  - Search starts at the pointer and wraps modulo NUM_CHANNELS.
  - On a grant to channel k, pointer <= (k+1) mod NUM_CHANNELS.
  - With no grant, the pointer holds.
- Fixed priority (ARB_MODE=1): lowest asserted index wins; the pointer is unused.
- Stall hold: while wb_done=1 and wb_ack=0, wb_id, wb_rd and the stored flags stay stable and no in_ack is issued.
- Channel obligations: a channel holds in_done and its data until it sees in_ack; the arbiter never drops a request.
- fflags (combinational, from registered state):
  - fp_acc = wb_done & wb_ack; int_acc = int_done & int_ack.
  - Both accepted: fflags = stored_flags | int_fflags.
  - fp_acc only: fflags = stored_flags.
  - int_acc only: fflags = int_fflags.
  - Neither: fflags = 0.
- Reset mid-stall: the pending output is discarded (wb_done=0 next cycle); upstream channels re-present their requests.
- NUM_CHANNELS=2: the pointer is a single bit; behaviour is otherwise identical.

Optional Feature:
- Macro: FP_WB_ARB_STICKY_FFLAGS_EN.
- When defined:
  - Adds input sticky_clr (1 bit) and output sticky_fflags (5 bits).
  - sticky_fflags <= (sticky_clr ? 0 : sticky_fflags) | fflags each cycle, so a same-cycle accepted flag survives a clear.
  - Reset value 0.
- When undefined: the ports and register are absent; fflags behaviour is unchanged.

Test Plan:
- Round-robin fairness: ARB_MODE=0, NUM_CHANNELS=4, all in_done=1 continuously, wb_ack=1 -> in_ack sequence 0001,0010,0100,1000,0001; wb_id follows the channel ids with 1-cycle latency, one result per cycle.
- Back-pressure hold: channel 2 valid with rd=0x3FF0000000000000 and id=5, wb_ack held 0 for 3 cycles -> wb_done=1 and data stable, in_ack=0 throughout; on the wb_ack=1 cycle a waiting channel 1 receives in_ack in that same cycle.
- Fixed priority: ARB_MODE=1, in_done=1010 -> channel 1 granted repeatedly until it drops in_done, then channel 3.
- Flag merge: stored flags=00001 (NX) with wb_ack=1, int_done=int_ack=1 with int_fflags=10000 -> fflags=10001; int only -> 10000; fp only -> 00001; neither -> 00000.
- Reset mid-stall: wb_done=1, wb_ack=0, rst pulsed for 1 cycle -> wb_done=0, pointer=0, and the next grant goes to the lowest pending channel.
- Sticky flags (macro on): accept OF then UF -> sticky=00110; sticky_clr in the same cycle as an NX acceptance -> sticky=00001.

Source files
------------

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - N-channel FP writeback arbiter with registered output and fflags merge
// Optional sticky flag accumulator: FP_WB_ARB_STICKY_FFLAGS_EN
module fp_wb_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 3,
    parameter int ARB_MODE     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS-1:0]          in_done,
    input  logic [NUM_CHANNELS*ID_WIDTH-1:0] in_id,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_rd,
    input  logic [NUM_CHANNELS*5-1:0]        in_fflags,
    output logic [NUM_CHANNELS-1:0]          in_ack,
    output logic                             wb_done,
    output logic [ID_WIDTH-1:0]              wb_id,
    output logic [DATA_WIDTH-1:0]            wb_rd,
    input  logic                             wb_ack,
    input  logic                             int_done,
    input  logic                             int_ack,
    input  logic [4:0]                       int_fflags,
    output logic [4:0]                       fflags,
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
    input  logic                             sticky_clr,
    output logic [4:0]                       sticky_fflags,
`endif
    output logic                             busy
);

    localparam int PTR_W = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_vld;
    logic                  load_en;
    int                    start_pos;
    logic [4:0]            stored_flags;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DATA_WIDTH-1:0] sel_rd;
    logic [4:0]            sel_flags;
    logic                  fp_acc;
    logic                  int_acc;

    assign load_en   = ~wb_done | wb_ack;
    assign start_pos = (ARB_MODE == 1) ? 0 : int'(ptr);
    assign busy      = wb_done | (|in_done);

    // Grant depends only on in_done, ptr and load_en; data never feeds back into it.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        in_ack    = '0;
        if (load_en) begin
            for (int off = 0; off < NUM_CHANNELS; off++) begin
                if (!grant_vld && in_done[(start_pos + off) % NUM_CHANNELS]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'((start_pos + off) % NUM_CHANNELS);
                    in_ack[(start_pos + off) % NUM_CHANNELS] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_id    = '0;
        sel_rd    = '0;
        sel_flags = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (in_ack[i]) begin
                sel_id    = in_id[i*ID_WIDTH +: ID_WIDTH];
                sel_rd    = in_rd[i*DATA_WIDTH +: DATA_WIDTH];
                sel_flags = in_fflags[i*5 +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_done      <= 1'b0;
            wb_id        <= '0;
            wb_rd        <= '0;
            stored_flags <= '0;
            ptr          <= '0;
        end else if (load_en) begin
            wb_done <= grant_vld;
            if (grant_vld) begin
                wb_id        <= sel_id;
                wb_rd        <= sel_rd;
                stored_flags <= sel_flags;
                if (ARB_MODE == 0) begin
                    ptr <= (grant_idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);
                end
            end
        end
    end

    assign fp_acc  = wb_done & wb_ack;
    assign int_acc = int_done & int_ack;

    always_comb begin
        fflags = 5'b0;
        if (fp_acc && int_acc) begin
            fflags = stored_flags | int_fflags;
        end else if (fp_acc) begin
            fflags = stored_flags;
        end else if (int_acc) begin
            fflags = int_fflags;
        end
    end

`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
    // The clear applies to the old value only, so flags accepted this cycle survive it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_fflags <= 5'b0;
        end else begin
            sticky_fflags <= (sticky_clr ? 5'b0 : sticky_fflags) | fflags;
        end
    end
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - scoreboard bench for fp_wb_arbiter (round-robin and fixed-priority instances)
module tb_fp_wb_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [63:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ch_id [4];
    logic [63:0] ch_rd [4];
    logic [4:0]  ch_ff [4];
    logic [11:0]  p_id;
    logic [255:0] p_rd;
    logic [19:0]  p_ff;

    logic [3:0]  a_in_done, a_in_ack;
    logic        a_wb_done, a_wb_ack, a_busy;
    logic [2:0]  a_wb_id;
    logic [63:0] a_wb_rd;
    logic        a_int_done, a_int_ack;
    logic [4:0]  a_int_fflags, a_fflags;
    logic        a_sticky_clr;
    logic [4:0]  a_sticky;

    logic [3:0]  b_in_done, b_in_ack;
    logic        b_wb_done, b_wb_ack, b_busy;
    logic [2:0]  b_wb_id;
    logic [63:0] b_wb_rd;
    logic [4:0]  b_fflags;
    logic [4:0]  b_sticky;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    always_comb begin
        p_id = '0;
        p_rd = '0;
        p_ff = '0;
        for (int i = 0; i < 4; i++) begin
            p_id[i*3 +: 3]   = ch_id[i];
            p_rd[i*64 +: 64] = ch_rd[i];
            p_ff[i*5 +: 5]   = ch_ff[i];
        end
    end

    fp_wb_arbiter #(.NUM_CHANNELS(4), .DATA_WIDTH(64), .ID_WIDTH(3), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .in_done(a_in_done), .in_id(p_id), .in_rd(p_rd), .in_fflags(p_ff),
        .in_ack(a_in_ack), .wb_done(a_wb_done), .wb_id(a_wb_id), .wb_rd(a_wb_rd),
        .wb_ack(a_wb_ack), .int_done(a_int_done), .int_ack(a_int_ack),
        .int_fflags(a_int_fflags), .fflags(a_fflags),
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        .sticky_clr(a_sticky_clr), .sticky_fflags(a_sticky),
`endif
        .busy(a_busy)
    );

    fp_wb_arbiter #(.NUM_CHANNELS(4), .DATA_WIDTH(64), .ID_WIDTH(3), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .in_done(b_in_done), .in_id(p_id), .in_rd(p_rd), .in_fflags(p_ff),
        .in_ack(b_in_ack), .wb_done(b_wb_done), .wb_id(b_wb_id), .wb_rd(b_wb_rd),
        .wb_ack(b_wb_ack), .int_done(1'b0), .int_ack(1'b0),
        .int_fflags(5'b0), .fflags(b_fflags),
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        .sticky_clr(1'b0), .sticky_fflags(b_sticky),
`endif
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of dut_rr: check the grant, retire an accepted output, record new grants.
    task automatic step(input logic [3:0] exp_ack, input string tag);
        exp_t e;
        #1;
        chk({tag, " in_ack"}, 64'(a_in_ack), 64'(exp_ack));
        if (a_wb_done && a_wb_ack) begin
            if (q.size() == 0) begin
                chk({tag, " unexpected output"}, 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk({tag, " wb_id"}, 64'(a_wb_id), 64'(e.id));
                chk({tag, " wb_rd"}, a_wb_rd, e.rd);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_ack[i]) q.push_back({ch_id[i], ch_rd[i]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ch_id[0] = 3'd6; ch_id[1] = 3'd1; ch_id[2] = 3'd5; ch_id[3] = 3'd2;
        ch_rd[0] = 64'h0123_4567_89AB_CDEF;
        ch_rd[1] = 64'hC000_0000_0000_0001;
        ch_rd[2] = 64'h3FF0_0000_0000_0000;
        ch_rd[3] = 64'h7FF8_0000_0000_0000;
        for (int i = 0; i < 4; i++) ch_ff[i] = 5'b0;
        rst = 1'b1;
        a_in_done = '0; a_wb_ack = 1'b0;
        a_int_done = 1'b0; a_int_ack = 1'b0; a_int_fflags = '0; a_sticky_clr = 1'b0;
        b_in_done = '0; b_wb_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        chk("reset wb_done", 64'(a_wb_done), 64'd0);
        chk("reset wb_id", 64'(a_wb_id), 64'd0);
        chk("reset wb_rd", a_wb_rd, 64'd0);
        chk("reset in_ack", 64'(a_in_ack), 64'd0);
        chk("reset fflags", 64'(a_fflags), 64'd0);
        chk("reset busy", 64'(a_busy), 64'd0);
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        chk("reset sticky", 64'(a_sticky), 64'd0);
`endif

        // Round-robin fairness with all channels pending.
        a_in_done = 4'b1111; a_wb_ack = 1'b1;
        step(4'b0001, "rr0");
        chk("rr wb_done", 64'(a_wb_done), 64'd1);
        step(4'b0010, "rr1");
        step(4'b0100, "rr2");
        step(4'b1000, "rr3");
        step(4'b0001, "rr4");
        step(4'b0010, "rr5");
        a_in_done = 4'b0000;
        step(4'b0000, "rr drain");
        chk("rr queue empty", 64'(q.size()), 64'd0);
        chk("rr idle wb_done", 64'(a_wb_done), 64'd0);

        // Back-pressure: channel 2 stalls three cycles while channel 1 waits.
        a_wb_ack = 1'b0; a_in_done = 4'b0100;
        step(4'b0100, "bp load");
        a_in_done = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, "bp stall");
            chk("bp wb_done", 64'(a_wb_done), 64'd1);
            chk("bp wb_id", 64'(a_wb_id), 64'd5);
            chk("bp wb_rd", a_wb_rd, 64'h3FF0_0000_0000_0000);
            chk("bp busy", 64'(a_busy), 64'd1);
        end
        a_wb_ack = 1'b1;
        step(4'b0010, "bp release");
        a_in_done = 4'b0000;
        step(4'b0000, "bp drain");

        // Flag merge against a stored NX result.
        ch_ff[0] = 5'b00001;
        a_wb_ack = 1'b0; a_in_done = 4'b0001;
        step(4'b0001, "ff load");
        a_in_done = 4'b0000;
        a_wb_ack = 1'b1; a_int_done = 1'b1; a_int_ack = 1'b1; a_int_fflags = 5'b10000;
        #1 chk("ff both", 64'(a_fflags), 64'b10001);
        a_wb_ack = 1'b0;
        #1 chk("ff int only", 64'(a_fflags), 64'b10000);
        a_wb_ack = 1'b1; a_int_ack = 1'b0;
        #1 chk("ff fp only", 64'(a_fflags), 64'b00001);
        a_wb_ack = 1'b0;
        #1 chk("ff neither", 64'(a_fflags), 64'b00000);
        a_wb_ack = 1'b1; a_int_done = 1'b0;
        step(4'b0000, "ff retire");

        // Sticky accumulation and clear-with-acceptance.
        a_sticky_clr = 1'b1;
        step(4'b0000, "st clear");
        a_sticky_clr = 1'b0;
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        chk("sticky cleared", 64'(a_sticky), 64'd0);
`endif
        ch_ff[3] = 5'b00100; a_in_done = 4'b1000;
        step(4'b1000, "st of");
        ch_ff[3] = 5'b00010;
        step(4'b1000, "st uf");
        a_in_done = 4'b0000;
        step(4'b0000, "st drain");
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        chk("sticky of|uf", 64'(a_sticky), 64'b00110);
`endif
        a_in_done = 4'b0001;
        step(4'b0001, "st nx");
        a_in_done = 4'b0000; a_sticky_clr = 1'b1;
        step(4'b0000, "st clr+nx");
        a_sticky_clr = 1'b0;
`ifdef FP_WB_ARB_STICKY_FFLAGS_EN
        chk("sticky clr+nx", 64'(a_sticky), 64'b00001);
`endif

        // Reset while stalled: pending entry dropped, pointer back to 0.
        a_wb_ack = 1'b0; a_in_done = 4'b0010;
        step(4'b0010, "rs load");
        a_in_done = 4'b0000;
        chk("rs stalled wb_done", 64'(a_wb_done), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        chk("rs wb_done", 64'(a_wb_done), 64'd0);
        a_in_done = 4'b1010; a_wb_ack = 1'b1;
        step(4'b0010, "rs regrant");
        a_in_done = 4'b0000;
        step(4'b0000, "rs drain");
        chk("rs queue empty", 64'(q.size()), 64'd0);

        // Fixed priority: channel 1 wins until it drops, then channel 3.
        b_in_done = 4'b1010; b_wb_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("fp ch1 grant", 64'(b_in_ack), 64'b0010);
            @(posedge clk); #1;
            chk("fp ch1 wb_id", 64'(b_wb_id), 64'(ch_id[1]));
        end
        b_in_done = 4'b1000;
        #1 chk("fp ch3 grant", 64'(b_in_ack), 64'b1000);
        @(posedge clk); #1;
        b_in_done = 4'b0000;
        chk("fp ch3 wb_done", 64'(b_wb_done), 64'd1);
        chk("fp ch3 wb_id", 64'(b_wb_id), 64'(ch_id[3]));
        chk("fp ch3 wb_rd", b_wb_rd, ch_rd[3]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
